prbs_link_sequencer: RTL and testbench



---
 rtl/prbs_link_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_prbs_link_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/prbs_link_sequencer.sv
// rtl/prbs_link_sequencer.sv - PRBS-15 link test sequencer: alignment pattern burst, detector wait, PRBS handover.
// Optional WAIT-timeout retries are built when PRBS_SEQ_RETRY_EN is defined.
module prbs_link_sequencer #(
  parameter int TO_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic [31:0]     cfg_pattern,
  input  logic [7:0]      cfg_n,
  input  logic [TO_W-1:0] cfg_timeout,
  input  logic            det_valid,
  output logic            det_enable,
  output logic [31:0]     det_pattern,
  output logic [7:0]      det_n,
  output logic [7:0]      tx_byte,
  output logic            tx_valid,
  output logic            prbs_enable,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            timeout_err
);

  typedef enum logic [1:0] {IDLE, TX_PAT, WAIT, PRBS} state_t;

  state_t          state, state_nx;
  logic [1:0]      idx, idx_nx;
  logic [7:0]      rep, rep_nx;
  logic [TO_W-1:0] cnt, cnt_nx, to_q, to_nx;
  logic [31:0]     pat_nx;
  logic [7:0]      n_nx;
  logic            flag, flag_nx;
  logic            pass_nx, terr_nx, done_nx;
  logic            det_enable_d, tx_valid_d, prbs_enable_d, busy_d;
  logic [7:0]      tx_byte_d;
`ifdef PRBS_SEQ_RETRY_EN
  logic [1:0]      retry, retry_nx;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 2'd0;
      rep         <= 8'd0;
      cnt         <= '0;
      to_q        <= '0;
      det_pattern <= 32'd0;
      det_n       <= 8'd0;
      flag        <= 1'b0;
      pass        <= 1'b0;
      timeout_err <= 1'b0;
      done        <= 1'b0;
      det_enable  <= 1'b0;
      tx_valid    <= 1'b0;
      tx_byte     <= 8'd0;
      prbs_enable <= 1'b0;
      busy        <= 1'b0;
`ifdef PRBS_SEQ_RETRY_EN
      retry       <= 2'd0;
`endif
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      rep         <= rep_nx;
      cnt         <= cnt_nx;
      to_q        <= to_nx;
      det_pattern <= pat_nx;
      det_n       <= n_nx;
      flag        <= flag_nx;
      pass        <= pass_nx;
      timeout_err <= terr_nx;
      done        <= done_nx;
      det_enable  <= det_enable_d;
      tx_valid    <= tx_valid_d;
      tx_byte     <= tx_byte_d;
      prbs_enable <= prbs_enable_d;
      busy        <= busy_d;
`ifdef PRBS_SEQ_RETRY_EN
      retry       <= retry_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    rep_nx   = rep;
    cnt_nx   = cnt;
    to_nx    = to_q;
    pat_nx   = det_pattern;
    n_nx     = det_n;
    flag_nx  = flag;
    pass_nx  = pass;
    terr_nx  = timeout_err;
    done_nx  = 1'b0;
`ifdef PRBS_SEQ_RETRY_EN
    retry_nx = retry;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          pat_nx   = cfg_pattern;
          n_nx     = cfg_n;
          to_nx    = cfg_timeout;
          pass_nx  = 1'b0;
          terr_nx  = 1'b0;
          idx_nx   = 2'd0;
          rep_nx   = 8'd0;
          cnt_nx   = '0;
          flag_nx  = 1'b0;
`ifdef PRBS_SEQ_RETRY_EN
          retry_nx = 2'd0;
`endif
          state_nx = (cfg_n == 8'd0) ? WAIT : TX_PAT;
        end
      end
      TX_PAT: begin
        if (det_valid) flag_nx = 1'b1;
        idx_nx = idx + 2'd1;
        if (idx == 2'd3) begin
          rep_nx = rep + 8'd1;
          if (rep == det_n - 8'd1) begin
            state_nx = WAIT;
            cnt_nx   = '0;
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt + TO_W'(1);
        // An early detection recorded during TX_PAT counts the same as a live one.
        if (det_valid || flag) begin
          state_nx = PRBS;
        end else if (cnt == to_q) begin
`ifdef PRBS_SEQ_RETRY_EN
          if (retry != 2'd3) begin
            retry_nx = retry + 2'd1;
            idx_nx   = 2'd0;
            rep_nx   = 8'd0;
            cnt_nx   = '0;
            flag_nx  = 1'b0;
            state_nx = (det_n == 8'd0) ? WAIT : TX_PAT;
          end else begin
            state_nx = IDLE;
            done_nx  = 1'b1;
            pass_nx  = 1'b0;
            terr_nx  = 1'b1;
          end
`else
          state_nx = IDLE;
          done_nx  = 1'b1;
          pass_nx  = 1'b0;
          terr_nx  = 1'b1;
`endif
        end
      end
      PRBS: begin
        if (stop) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          pass_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decode the upcoming state so they land in registers aligned with it.
  always_comb begin
    det_enable_d  = (state_nx == TX_PAT) || (state_nx == WAIT);
    tx_valid_d    = (state_nx == TX_PAT);
    prbs_enable_d = (state_nx == PRBS);
    busy_d        = (state_nx != IDLE);
    tx_byte_d     = 8'd0;
    if (state_nx == TX_PAT) begin
      case (idx_nx)
        2'd0:    tx_byte_d = pat_nx[31:24];
        2'd1:    tx_byte_d = pat_nx[23:16];
        2'd2:    tx_byte_d = pat_nx[15:8];
        default: tx_byte_d = pat_nx[7:0];
      endcase
    end
  end

endmodule

// File: tb/tb_prbs_link_sequencer.sv
// tb/tb_prbs_link_sequencer.sv - directed self-checking bench for prbs_link_sequencer.
module tb_prbs_link_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, stop, det_valid;
  logic [31:0] cfg_pattern;
  logic [7:0]  cfg_n;
  logic [15:0] cfg_timeout;
  logic        det_enable, tx_valid, prbs_enable, busy, done, pass, timeout_err;
  logic [31:0] det_pattern;
  logic [7:0]  det_n, tx_byte;

  int n_cmp = 0;
  int n_err = 0;

  prbs_link_sequencer #(.TO_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_pattern(cfg_pattern), .cfg_n(cfg_n), .cfg_timeout(cfg_timeout),
    .det_valid(det_valid), .det_enable(det_enable), .det_pattern(det_pattern),
    .det_n(det_n), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .prbs_enable(prbs_enable), .busy(busy), .done(done), .pass(pass),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] p, input logic [7:0] n, input logic [15:0] t);
    cfg_pattern = p;
    cfg_n       = n;
    cfg_timeout = t;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic check_bytes(input string tag, input logic [31:0] p, input int reps);
    logic [31:0] w;
    for (int r = 0; r < reps; r++) begin
      w = p;
      for (int b = 0; b < 4; b++) begin
        check({tag, "_valid"}, tx_valid, 1'b1);
        check({tag, "_byte"}, tx_byte, w[31:24]);
        w = w << 8;
        tick();
      end
    end
  endtask

  int tx_cnt, done_cnt;
`ifdef PRBS_SEQ_RETRY_EN
  localparam int FAIL_T2 = 41;
  localparam int TX_T2   = 12;
  localparam int FAIL_T0 = 5;
`else
  localparam int FAIL_T2 = 11;
  localparam int TX_T2   = 0;
  localparam int FAIL_T0 = 2;
`endif

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; det_valid = 1'b0;
    cfg_pattern = 32'h0; cfg_n = 8'h0; cfg_timeout = 16'h0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_det_en", det_enable, 1'b0);
    check("rst_prbs", prbs_enable, 1'b0);
    check("rst_done_pass_terr", {done, pass, timeout_err}, 3'b000);
    check("rst_det_pattern", det_pattern, 32'h0);

    // Basic pass: n=2, detection in WAIT cycle index 3
    do_start(32'hA5C3_0F96, 8'd2, 16'd100);
    check_bytes("t1", 32'hA5C3_0F96, 2);
    check("t1_wait_tx", tx_valid, 1'b0);
    check("t1_wait_det_en", det_enable, 1'b1);
    check("t1_det_n", det_n, 8'd2);
    tick(); tick(); tick();
    check("t1_wait_prbs", prbs_enable, 1'b0);
    det_valid = 1'b1;
    tick();
    det_valid = 1'b0;
    check("t1_prbs", prbs_enable, 1'b1);
    check("t1_prbs_det_en", det_enable, 1'b0);
    tick(); tick();
    do_stop();
    check("t1_done", done, 1'b1);
    check("t1_pass", pass, 1'b1);
    check("t1_busy", busy, 1'b0);
    check("t1_prbs_off", prbs_enable, 1'b0);
    tick();
    check("t1_done_1cyc", done, 1'b0);
    check("t1_pass_sticky", pass, 1'b1);

    // Timeout: n=1, T=5, no detection
    do_start(32'h0102_0304, 8'd1, 16'd5);
    check("t2_pass_clr", pass, 1'b0);
    tick(); tick(); tick(); tick();
    tx_cnt = 0; done_cnt = 0;
    for (int c = 5; c < FAIL_T2; c++) begin
      tx_cnt   += int'(tx_valid);
      done_cnt += int'(done);
      tick();
    end
    check("t2_no_early_done", done_cnt, 0);
    check("t2_resent_bytes", tx_cnt, TX_T2);
    check("t2_done", done, 1'b1);
    check("t2_terr", timeout_err, 1'b1);
    check("t2_pass", pass, 1'b0);
    tick();

    // n=0, T=0: detection wins over timeout on the first WAIT cycle
    do_start(32'hFFFF_FFFF, 8'd0, 16'd0);
    check("t3_no_tx", tx_valid, 1'b0);
    check("t3_busy", busy, 1'b1);
    check("t3_terr_clr", timeout_err, 1'b0);
    det_valid = 1'b1;
    tick();
    det_valid = 1'b0;
    check("t3_prbs", prbs_enable, 1'b1);
    check("t3_no_done", done, 1'b0);
    do_stop();
    check("t3_pass", pass, 1'b1);
    tick();

    // n=0, T=0 without detection fails immediately
    do_start(32'h0, 8'd0, 16'd0);
    for (int c = 1; c < FAIL_T0; c++) tick();
    check("t3b_done", done, 1'b1);
    check("t3b_terr", timeout_err, 1'b1);
    tick();

    // Early detection during TX_PAT of n=3
    do_start(32'h0123_4567, 8'd3, 16'd50);
    check_bytes("t4a", 32'h0123_4567, 1);
    det_valid = 1'b1;
    check_bytes("t4b", 32'h0123_4567, 1);
    det_valid = 1'b0;
    check_bytes("t4c", 32'h0123_4567, 1);
    check("t4_wait", {tx_valid, det_enable, prbs_enable}, 3'b010);
    tick();
    check("t4_prbs", prbs_enable, 1'b1);
    do_stop();
    check("t4_done", done, 1'b1);
    tick();

    // Reset mid-test during byte 5 of n=4
    do_start(32'hDEAD_BEEF, 8'd4, 16'd50);
    check_bytes("t5", 32'hDEAD_BEEF, 1);
    check("t5_b5", tx_byte, 8'hDE);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_outs", {busy, tx_valid, det_enable, prbs_enable, done, pass, timeout_err}, 7'd0);
    check("t5_tx_byte", tx_byte, 8'h0);
    check("t5_det_pattern", det_pattern, 32'h0);
    check("t5_det_n", det_n, 8'h0);
    tick();
    check("t5_no_done", done, 1'b0);
    do_start(32'h1122_3344, 8'd1, 16'd50);
    check("t5_restart_b0", tx_byte, 8'h11);

    rst = 1'b1; tick(); rst = 1'b0;

    // Ignored start in WAIT and stop in TX_PAT
    do_start(32'hCAFE_F00D, 8'd1, 16'd20);
    check("t6_b0", tx_byte, 8'hCA);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t6_b1", tx_byte, 8'hFE);
    check("t6_busy", busy, 1'b1);
    tick(); tick();
    check("t6_b3", tx_byte, 8'h0D);
    tick();
    do_start(32'h1234_5678, 8'd9, 16'd2);
    check("t6_wait_tx", tx_valid, 1'b0);
    check("t6_pattern_kept", det_pattern, 32'hCAFE_F00D);
    check("t6_n_kept", det_n, 8'd1);
    tick(); tick();
    check("t6_no_timeout", {done, busy}, 2'b01);
    det_valid = 1'b1;
    tick();
    det_valid = 1'b0;
    check("t6_prbs", prbs_enable, 1'b1);
    do_stop();
    check("t6_done_pass", {done, pass}, 2'b11);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
